// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package stopwatch_pkg;

    localparam int unsigned DIGIT_W     = 5;
    localparam int unsigned SEC_MAX_DEF = 59;
    localparam int unsigned MIN_MAX_DEF = 59;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef struct packed {
        digit_t tens;
        digit_t units;
    } bcd2_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSE  = 2'd1,
        ADJUST = 2'd2
    } state_t;

    // Binary 0..99 to a two-digit BCD pair.
    function automatic bcd2_t to_bcd2(input int unsigned v);
        bcd2_t r;
        r.tens  = DIGIT_W'(v / 10);
        r.units = DIGIT_W'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_counter_bcd.sv
// Two-digit BCD counter that wraps to 00 after reaching max.
module bcd_mod_counter
    import stopwatch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    input  logic [2*DIGIT_W-1:0]   max,
    output logic [DIGIT_W-1:0]     tens,
    output logic [DIGIT_W-1:0]     units,
    output logic                   at_max
);

    bcd2_t max_bcd;

    assign max_bcd = max;
    assign at_max  = (tens == max_bcd.tens) && (units == max_bcd.units);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tens  <= '0;
            units <= '0;
        end else if (inc) begin
            if (at_max) begin
                tens  <= '0;
                units <= '0;
            end else if (units == DIGIT_W'(9)) begin
                tens  <= tens + DIGIT_W'(1);
                units <= '0;
            end else begin
                units <= units + DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS timekeeping core: 1 Hz counting, run/pause toggle, 2 Hz field adjust.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned SEC_MAX = SEC_MAX_DEF,
    parameter int unsigned MIN_MAX = MIN_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               pause,
    input  logic               adj,
    input  logic               sel,
    output logic [DIGIT_W-1:0] min_l,
    output logic [DIGIT_W-1:0] min_r,
    output logic [DIGIT_W-1:0] sec_l,
    output logic [DIGIT_W-1:0] sec_r,
    output logic               adj_out,
    output logic               running,
    output logic               wrap
);

    localparam bcd2_t SEC_MAX_BCD = to_bcd2(SEC_MAX);
    localparam bcd2_t MIN_MAX_BCD = to_bcd2(MIN_MAX);

    state_t state, state_nxt;
    logic   paused, paused_nxt_c;
    logic   pause_q, pause_rise_c;
    logic   sec_inc_c, min_inc_c, wrap_c;
    logic   sec_at_max, min_at_max;

    // State register plus the paused flag and pause edge detector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            paused  <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            paused  <= paused_nxt_c;
            pause_q <= pause;
        end
    end

    // Next state follows the post-toggle paused flag; adj overrides all.
    always_comb begin
        pause_rise_c = pause && !pause_q && !adj;
        paused_nxt_c = paused ^ pause_rise_c;
        state_nxt    = RUN;
        if (adj)               state_nxt = ADJUST;
        else if (paused_nxt_c) state_nxt = PAUSE;
    end

    // Counter strobes are decided by the pre-transition state.
    always_comb begin
        sec_inc_c = 1'b0;
        min_inc_c = 1'b0;
        wrap_c    = 1'b0;
        case (state)
            RUN: begin
                sec_inc_c = tick_1hz;
                min_inc_c = tick_1hz && sec_at_max;
                wrap_c    = tick_1hz && sec_at_max && min_at_max;
            end
            ADJUST: begin
                sec_inc_c = tick_2hz && sel;
                min_inc_c = tick_2hz && !sel;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running <= 1'b1;
            wrap    <= 1'b0;
            adj_out <= 1'b0;
        end else begin
            running <= (state_nxt == RUN);
            wrap    <= wrap_c;
            adj_out <= adj;
        end
    end

    bcd_mod_counter u_sec (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (sec_inc_c),
        .max    (SEC_MAX_BCD),
        .tens   (sec_l),
        .units  (sec_r),
        .at_max (sec_at_max)
    );

    bcd_mod_counter u_min (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (min_inc_c),
        .max    (MIN_MAX_BCD),
        .tens   (min_l),
        .units  (min_r),
        .at_max (min_at_max)
    );

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter.
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       rst_n, tick_1hz, tick_2hz, pause, adj, sel;
    logic [4:0] min_l, min_r, sec_l, sec_r;
    logic       adj_out, running, wrap;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_counter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_1hz (tick_1hz),
        .tick_2hz (tick_2hz),
        .pause    (pause),
        .adj      (adj),
        .sel      (sel),
        .min_l    (min_l),
        .min_r    (min_r),
        .sec_l    (sec_l),
        .sec_r    (sec_r),
        .adj_out  (adj_out),
        .running  (running),
        .wrap     (wrap)
    );

    function automatic logic [19:0] mmss(input int m, input int s);
        return {5'(m / 10), 5'(m % 10), 5'(s / 10), 5'(s % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int m, input int s);
        chk(tag, 32'({min_l, min_r, sec_l, sec_r}), 32'(mmss(m, s)));
    endtask

    // One clock; inputs were set 1 ns after the previous edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick1(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            cyc();
            tick_1hz = 1'b0;
        end
    endtask

    task automatic tick2(input int n);
        for (int i = 0; i < n; i++) begin
            tick_2hz = 1'b1;
            cyc();
            tick_2hz = 1'b0;
        end
    endtask

    task automatic press();
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0;
        pause = 1'b0; adj = 1'b0; sel = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        chk_time("reset_time", 0, 0);
        chk("reset_running", 32'(running), 32'd1);
        chk("reset_wrap", 32'(wrap), 32'd0);
        chk("reset_adj_out", 32'(adj_out), 32'd0);

        // 65 seconds of running
        tick1(65);
        chk_time("run65", 1, 5);
        chk("run65_running", 32'(running), 32'd1);

        // Preload 59:58 through adjust mode
        adj = 1'b1;
        cyc();
        chk("adj_out_set", 32'(adj_out), 32'd1);
        chk("adj_running", 32'(running), 32'd0);
        sel = 1'b0; tick2(58);
        chk("adj_min_wrap_no_pulse", 32'(wrap), 32'd0);
        sel = 1'b1; tick2(53);
        chk_time("preload", 59, 58);
        adj = 1'b0;
        cyc();
        chk("exit_adj_running", 32'(running), 32'd1);
        tick1(1);
        chk("wrap_early", 32'(wrap), 32'd0);
        tick1(1);
        chk_time("rollover", 0, 0);
        chk("wrap_pulse", 32'(wrap), 32'd1);
        cyc();
        chk("wrap_one_cycle", 32'(wrap), 32'd0);
        tick1(1);
        chk_time("after_roll", 0, 1);

        // Pause and resume
        tick1(9);
        chk_time("at_10", 0, 10);
        press();
        chk("paused_running", 32'(running), 32'd0);
        tick1(5);
        chk_time("paused_hold", 0, 10);
        press();
        tick1(1);
        chk_time("resumed", 0, 11);
        chk("resumed_running", 32'(running), 32'd1);

        // Seconds adjust from 00:58 with interleaved 1 Hz strobes
        tick1(47);
        chk_time("at_58", 0, 58);
        adj = 1'b1; sel = 1'b1;
        cyc();
        tick2(1);
        tick1(1);
        tick_1hz = 1'b1; tick_2hz = 1'b1;
        cyc();
        tick_1hz = 1'b0; tick_2hz = 1'b0;
        tick2(1);
        chk_time("adj_sec", 0, 1);
        chk("adj_sec_wrap", 32'(wrap), 32'd0);
        sel = 1'b0;
        tick2(2);
        tick1(2);
        chk_time("adj_min", 2, 1);

        // Move to 00:20 and exit adjust
        tick2(58);
        sel = 1'b1; tick2(19);
        chk_time("adj_to_20", 0, 20);
        adj = 1'b0;
        cyc();

        // Pause edge coincident with a 1 Hz strobe still counts
        pause = 1'b1; tick_1hz = 1'b1;
        cyc();
        pause = 1'b0; tick_1hz = 1'b0;
        chk_time("tick_with_pause", 0, 21);
        chk("tick_with_pause_running", 32'(running), 32'd0);
        tick1(1);
        chk_time("paused_after_coincident", 0, 21);

        // Pause edge during adjust is ignored
        adj = 1'b1;
        cyc();
        press();
        adj = 1'b0;
        cyc();
        chk("adj_pause_ignored", 32'(running), 32'd0);
        tick1(1);
        chk_time("still_paused", 0, 21);
        press();
        tick1(1);
        chk_time("unpaused", 0, 22);
        chk("unpaused_running", 32'(running), 32'd1);

        // Reset mid-adjust at 12:34
        adj = 1'b1;
        cyc();
        sel = 1'b0; tick2(12);
        sel = 1'b1; tick2(12);
        chk_time("at_1234", 12, 34);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk_time("mid_adj_reset", 0, 0);
        chk("mid_adj_reset_running", 32'(running), 32'd1);
        chk("mid_adj_reset_adj_out", 32'(adj_out), 32'd0);
        cyc();
        chk("post_reset_adj_out", 32'(adj_out), 32'd1);
        chk("post_reset_adjust", 32'(running), 32'd0);
        adj = 1'b0;
        cyc();
        chk("post_reset_adj_out_low", 32'(adj_out), 32'd0);
        chk("post_reset_run", 32'(running), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
